// File: rtl/hazard_stall_control.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory
// wait freezes, with a saturating stall counter and a sticky memory-timeout flag.
package core_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
endpackage

module hazard_stall_control
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       if_id_opcode,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [6:0]       id_ex_opcode,
    input  logic [4:0]       id_ex_dest,
    input  logic             ex_branch_taken,
    input  logic             ex_mem_mem_req,
    input  logic             dmem_rvalid,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              load_use;
    logic              mem_stall;
    logic              branch;

    // Source-register usage of the instruction sitting in IF/ID
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (if_id_opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    // A just-serviced stall/flush must not retrigger on the same frozen/flushed instruction
    assign load_use  = (id_ex_opcode == OPC_LOAD) && (id_ex_dest != 5'd0)
                     && ((uses_rs1 && (if_id_rs1 == id_ex_dest))
                      || (uses_rs2 && (if_id_rs2 == id_ex_dest)))
                     && (state != ST_LU_STALL);
    assign mem_stall = ex_mem_mem_req && !dmem_rvalid;
    assign branch    = ex_branch_taken && (state != ST_FLUSH);

    assign fsm_state = reset ? ST_RUN : state;

    // Next state and pipeline controls, priority mem_stall > branch > load_use
    always_comb begin
        next_state     = ST_RUN;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        mem_wb_bubble  = 1'b0;
        if (mem_stall) begin
            next_state     = ST_MEM_WAIT;
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            mem_wb_bubble  = 1'b1;
        end else if (branch) begin
            next_state   = ST_FLUSH;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            next_state     = ST_LU_STALL;
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end
        if (reset) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            if_id_flush    = 1'b0;
            id_ex_bubble   = 1'b0;
            mem_wb_bubble  = 1'b0;
        end
    end

    // State, stall statistics and memory-wait watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            stall_cycles <= '0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state <= next_state;
            if (!pc_write_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (state == ST_MEM_WAIT) begin
                if (wait_cnt != WAIT_W'(TIMEOUT)) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_control.sv
// Self-checking bench for hazard_stall_control: directed hazard scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_hazard_stall_control;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] OPIMM  = 7'h13;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] JAL    = 7'h6f;
    localparam logic [6:0] LUI    = 7'h37;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    if_id_opcode;
    logic [4:0]    if_id_rs1;
    logic [4:0]    if_id_rs2;
    logic [6:0]    id_ex_opcode;
    logic [4:0]    id_ex_dest;
    logic          ex_branch_taken;
    logic          ex_mem_mem_req;
    logic          dmem_rvalid;
    logic          pc_write_en;
    logic          if_id_write_en;
    logic          id_ex_write_en;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          mem_wb_bubble;
    logic [1:0]    fsm_state;
    logic [CW-1:0] stall_cycles;
    logic          mem_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT, 3 FLUSH
    int m_state = 0;
    int m_stall = 0;
    int m_wait  = 0;
    bit m_to    = 1'b0;
    bit m_known = 1'b0;

    hazard_stall_control #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .if_id_opcode(if_id_opcode), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_opcode(id_ex_opcode), .id_ex_dest(id_ex_dest),
        .ex_branch_taken(ex_branch_taken), .ex_mem_mem_req(ex_mem_mem_req),
        .dmem_rvalid(dmem_rvalid),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_write_en(id_ex_write_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .fsm_state(fsm_state), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, check against the model, then advance the model
    task automatic cyc(input bit rst, input logic [6:0] ifop, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [6:0] exop, input logic [4:0] dst,
                       input bit br, input bit mq, input bit rv);
        bit         use1;
        bit         use2;
        bit         lu;
        bit         ms;
        bit         bt;
        int         act;
        logic [5:0] ectl;
        logic [5:0] gctl;
        @(negedge clk);
        reset           = rst;
        if_id_opcode    = ifop;
        if_id_rs1       = r1;
        if_id_rs2       = r2;
        id_ex_opcode    = exop;
        id_ex_dest      = dst;
        ex_branch_taken = br;
        ex_mem_mem_req  = mq;
        dmem_rvalid     = rv;
        #1;
        use1 = ifop inside {OP, OPIMM, LOAD, STORE, BRANCH, JALR};
        use2 = ifop inside {OP, STORE, BRANCH};
        lu   = (exop == LOAD) && (dst != 5'd0) && ((use1 && r1 == dst) || (use2 && r2 == dst))
               && (m_state != 1);
        ms   = mq && !rv;
        bt   = br && (m_state != 3);
        act  = ms ? 2 : (bt ? 3 : (lu ? 1 : 0));
        // {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, mem_wb_bubble}
        case (act)
            2:       ectl = 6'b000001;
            3:       ectl = 6'b111110;
            1:       ectl = 6'b001010;
            default: ectl = 6'b111000;
        endcase
        if (rst) ectl = 6'b000000;
        gctl = {pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush, id_ex_bubble,
                mem_wb_bubble};
        chk("ctl", 32'(gctl), 32'(ectl));
        chk("fsm_state", 32'(fsm_state), rst ? 32'd0 : 32'(m_state));
        if (m_known) begin
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
            chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
        end
        if (rst) begin
            m_state = 0;
            m_stall = 0;
            m_wait  = 0;
            m_to    = 1'b0;
            m_known = 1'b1;
        end else begin
            if (m_state == 2) begin
                m_wait++;
                if (m_wait >= int'(TO)) m_to = 1'b1;
            end else begin
                m_wait = 0;
            end
            if (!ectl[5] && m_stall < (2 ** CW) - 1) m_stall++;
            m_state = act;
        end
    endtask

    task automatic idle();
        cyc(1'b0, OPIMM, 5'd1, 5'd2, OPIMM, 5'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, OPIMM, 5'd0, 5'd0, OPIMM, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [6:0] opc_tab [8];

    initial begin
        opc_tab = '{LOAD, OPIMM, STORE, OP, BRANCH, JALR, JAL, LUI};

        // Reset behaviour
        do_reset();
        do_reset();
        chk("rst_pc_we", 32'(pc_write_en), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);

        // Load-use: LOAD x5 in ID/EX, OP reading x5 as rs2
        idle();
        cyc(1'b0, OP, 5'd1, 5'd5, LOAD, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_pc_we", 32'(pc_write_en), 32'd0);
        chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
        cyc(1'b0, OP, 5'd1, 5'd5, LOAD, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_state", 32'(fsm_state), 32'd1);
        chk("lu_once", 32'(pc_write_en), 32'd1);
        idle();
        chk("lu_run", 32'(fsm_state), 32'd0);
        chk("lu_cnt", 32'(stall_cycles), 32'd1);

        // Load to x0 never stalls
        do_reset();
        cyc(1'b0, OP, 5'd0, 5'd0, LOAD, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x0_pc_we", 32'(pc_write_en), 32'd1);
        idle();
        chk("x0_state", 32'(fsm_state), 32'd0);

        // Taken branch held two cycles: one flush only
        cyc(1'b0, OPIMM, 5'd1, 5'd2, OPIMM, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("br_flush1", 32'(if_id_flush), 32'd1);
        cyc(1'b0, OPIMM, 5'd1, 5'd2, OPIMM, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("br_flush2", 32'(if_id_flush), 32'd0);
        chk("br_state", 32'(fsm_state), 32'd3);
        idle();
        chk("br_run", 32'(fsm_state), 32'd0);

        // Memory wait: three frozen cycles, rvalid on the fourth
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, OPIMM, 5'd1, 5'd2, OPIMM, 5'd3, 1'b0, 1'b1, 1'b0);
            chk("mw_bubble", 32'(mem_wb_bubble), 32'd1);
        end
        cyc(1'b0, OPIMM, 5'd1, 5'd2, OPIMM, 5'd3, 1'b0, 1'b1, 1'b1);
        chk("mw_release", 32'(pc_write_en), 32'd1);
        idle();
        chk("mw_run", 32'(fsm_state), 32'd0);
        chk("mw_cnt", 32'(stall_cycles), 32'd3);

        // All three hazards at once: memory first, then the held branch, load-use dropped
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, OP, 5'd5, 5'd5, LOAD, 5'd5, 1'b1, 1'b1, 1'b0);
            chk("sim_freeze", 32'(id_ex_write_en), 32'd0);
        end
        cyc(1'b0, OP, 5'd5, 5'd5, LOAD, 5'd5, 1'b1, 1'b1, 1'b1);
        chk("sim_flush", 32'(if_id_flush), 32'd1);
        chk("sim_no_lu", 32'(pc_write_en), 32'd1);
        idle();
        chk("sim_state", 32'(fsm_state), 32'd3);
        idle();

        // Timeout after the fourth consecutive MEM_WAIT cycle, sticky until reset
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, OPIMM, 5'd1, 5'd2, OPIMM, 5'd3, 1'b0, 1'b1, 1'b0);
        chk("to_not_yet", 32'(mem_timeout), 32'd0);
        cyc(1'b0, OPIMM, 5'd1, 5'd2, OPIMM, 5'd3, 1'b0, 1'b1, 1'b0);
        chk("to_set", 32'(mem_timeout), 32'd1);
        cyc(1'b0, OPIMM, 5'd1, 5'd2, OPIMM, 5'd3, 1'b0, 1'b1, 1'b1);
        idle();
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        do_reset();
        idle();
        chk("to_cleared", 32'(mem_timeout), 32'd0);

        // Randomized traffic, including occasional mid-sequence resets
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 60) == 0,
                opc_tab[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                opc_tab[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
